compress_output_packer: RTL and testbench

- Sequences the compressor write path. Each cycle it takes up to two variable-length codewords (lane 0, lane 1), gated by the 2-bit write-control vector from the compress control-signal generator.
- Packs accepted codewords MSB-first into an accumulator and emits fixed OUT_W-bit words over a valid/ready interface.
- Applies backpressure to the match pipeline.
- On block end, flushes the partial word with zero padding.

---
 rtl/compress_output_packer.sv | 154 +++++++++++++++
 tb/tb_compress_output_packer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/compress_output_packer.sv
// Compressor write-path packer: merges up to two variable-length codewords per beat
// into an MSB-first bitstream of OUT_W-bit words. Optional stats: COMPRESS_PACK_STATS_EN.

module compress_pack_lane #(
    parameter int CODE_W = 34,
    parameter int LEN_W  = 6
) (
    input  logic              en,
    input  logic [CODE_W-1:0] code,
    input  logic [LEN_W-1:0]  len,
    output logic [CODE_W-1:0] code_eff,
    output logic [LEN_W-1:0]  len_eff
);
    logic [LEN_W-1:0] len_c;

    always_comb begin
        len_c = (int'(len) > CODE_W) ? LEN_W'(CODE_W) : len;
        len_eff = en ? len_c : '0;
        // Stray high bits above the length must never pollute the accumulator.
        code_eff = code & ~({CODE_W{1'b1}} << len_eff);
    end
endmodule

module compress_output_packer #(
    parameter int CODE_W = 34,
    parameter int LEN_W  = 6,
    parameter int OUT_W  = 32,
    parameter int ACC_W  = 128
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [1:0]        i_wr_control,
    input  logic [CODE_W-1:0] i_code0,
    input  logic [LEN_W-1:0]  i_len0,
    input  logic [CODE_W-1:0] i_code1,
    input  logic [LEN_W-1:0]  i_len1,
    input  logic              i_last,
    output logic [OUT_W-1:0]  o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_done,
    output logic [15:0]       o_word_count
`ifdef COMPRESS_PACK_STATS_EN
    ,
    output logic [31:0]       o_bit_count
`endif
);
    localparam int FILL_W = $clog2(ACC_W + 1);
    localparam int SH_W   = FILL_W + 1;

    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DONE} state_t;

    state_t              state, state_next;
    logic [ACC_W-1:0]    acc, acc_post, acc_next, ins0, ins1;
    logic [FILL_W-1:0]   fill, fill_post, fill_next, drained, len_sum;
    logic [SH_W-1:0]     sh0, sh1;
    logic                accept, drain;

    logic [1:0][CODE_W-1:0] code_in, code_eff;
    logic [1:0][LEN_W-1:0]  len_in, len_eff;

    assign code_in[0] = i_code0;
    assign code_in[1] = i_code1;
    assign len_in[0]  = i_len0;
    assign len_in[1]  = i_len1;

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_lane
            compress_pack_lane #(.CODE_W(CODE_W), .LEN_W(LEN_W)) u_lane (
                .en       (i_wr_control[g]),
                .code     (code_in[g]),
                .len      (len_in[g]),
                .code_eff (code_eff[g]),
                .len_eff  (len_eff[g])
            );
        end
    endgenerate

    // Handshake outputs depend on registers only; fill never exceeds ACC_W because
    // a beat is only taken while two worst-case codes still fit.
    assign o_ready = (state == S_RUN) && (fill <= FILL_W'(ACC_W - 2*CODE_W));
    assign o_valid = (fill >= FILL_W'(OUT_W)) || ((state == S_FLUSH) && (fill != '0));
    assign o_data  = o_valid ? acc[ACC_W-1 -: OUT_W] : '0;
    assign o_done  = (state == S_DONE);

    assign accept = i_valid && o_ready;
    assign drain  = o_valid && i_ready;

    always_comb begin
        drained   = '0;
        if (drain)
            drained = (fill >= FILL_W'(OUT_W)) ? FILL_W'(OUT_W) : fill;
        fill_post = fill - drained;
        acc_post  = drain ? (acc << OUT_W) : acc;

        len_sum = FILL_W'(len_eff[0]) + FILL_W'(len_eff[1]);
        // New codes land relative to the post-drain fill, lane 0 first.
        sh0  = SH_W'(ACC_W) - SH_W'(fill_post) - SH_W'(len_eff[0]);
        sh1  = sh0 - SH_W'(len_eff[1]);
        ins0 = ACC_W'(code_eff[0]) << sh0;
        ins1 = ACC_W'(code_eff[1]) << sh1;

        acc_next  = acc_post;
        fill_next = fill_post;
        if (accept) begin
            acc_next  = acc_post | ins0 | ins1;
            fill_next = fill_post + len_sum;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_RUN:   if (accept && i_last) state_next = S_FLUSH;
            S_FLUSH: if (fill == '0)       state_next = S_DONE;
            S_DONE:                        state_next = S_RUN;
            default:                       state_next = S_RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= S_RUN;
            acc          <= '0;
            fill         <= '0;
            o_word_count <= '0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            fill  <= fill_next;
            if (state == S_DONE)
                o_word_count <= '0;
            else if (drain)
                o_word_count <= o_word_count + 16'd1;
        end
    end

`ifdef COMPRESS_PACK_STATS_EN
    logic [32:0] bit_sum;
    assign bit_sum = {1'b0, o_bit_count} + 33'(len_sum);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            o_bit_count <= '0;
        else if (state == S_DONE)
            o_bit_count <= '0;
        else if (accept)
            o_bit_count <= bit_sum[32] ? 32'hFFFF_FFFF : bit_sum[31:0];
    end
`endif
endmodule

// File: tb/tb_compress_output_packer.sv
// Directed table for handshake/flush corners, then a bit-queue scoreboard over random traffic.

module tb_compress_output_packer;
    logic        clk = 1'b0;
    logic        rst_n, vld, last, rdy;
    logic [1:0]  wr;
    logic [33:0] c0, c1;
    logic [5:0]  l0, l1;
    logic        o_ready, o_valid, o_done;
    logic [31:0] o_data;
    logic [15:0] o_word_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    compress_output_packer dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (vld),
        .o_ready      (o_ready),
        .i_wr_control (wr),
        .i_code0      (c0),
        .i_len0       (l0),
        .i_code1      (c1),
        .i_len1       (l1),
        .i_last       (last),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (rdy),
        .o_done       (o_done),
        .o_word_count (o_word_count)
    );

    typedef struct {
        logic        rst_n, vld;
        logic [1:0]  wr;
        logic [33:0] c0;
        logic [5:0]  l0;
        logic [33:0] c1;
        logic [5:0]  l1;
        logic        last, rdy;
        logic        e_rdy, e_vld;
        logic [31:0] e_data;
        logic        e_done;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic r, logic v, logic [1:0] w, logic [33:0] a0, logic [5:0] b0,
                                logic [33:0] a1, logic [5:0] b1, logic la, logic rd,
                                logic er, logic ev, logic [31:0] ed, logic edn, logic [15:0] ec);
        vec_t t;
        t.rst_n = r;  t.vld = v;  t.wr = w;  t.c0 = a0;  t.l0 = b0;  t.c1 = a1;  t.l1 = b1;
        t.last = la;  t.rdy = rd; t.e_rdy = er; t.e_vld = ev; t.e_data = ed; t.e_done = edn;
        t.e_cnt = ec;
        return t;
    endfunction

    // Idle cycle with the given downstream ready.
    function automatic vec_t idle(logic rd, logic er, logic ev, logic [31:0] ed, logic edn,
                                  logic [15:0] ec);
        return mk(1, 0, 2'b00, 0, 0, 0, 0, 0, rd, er, ev, ed, edn, ec);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard state: pending bitstream, block state (0 run, 1 flush, 2 done), word count.
    bit q[$];
    int mst;
    int mcnt;

    initial begin
        rst_n = 1'b0; vld = 1'b0; wr = 2'b00; c0 = '0; l0 = '0; c1 = '0; l1 = '0;
        last = 1'b0; rdy = 1'b0;

        // Reset with busy inputs
        tv.push_back(mk(0, 1, 2'b11, 34'h3FFFFFFFF, 34, 34'h1234, 20, 1, 1, 1, 0, 0, 0, 0));
        tv.push_back(mk(0, 1, 2'b01, 34'h155, 9, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        // Eleven 3-bit codes 101, then flush the single leftover bit
        for (int i = 0; i < 10; i++)
            tv.push_back(mk(1, 1, 2'b01, 34'h5, 3, 34'h3, 7, 0, 1, 1, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 2'b01, 34'h5, 3, 0, 0, 0, 1, 1, 1, 32'hB6DB6DB6, 0, 0));
        tv.push_back(idle(1, 1, 0, 0, 0, 1));
        tv.push_back(mk(1, 1, 2'b00, 34'h3FF, 9, 0, 0, 1, 0, 0, 1, 32'h80000000, 0, 1));
        tv.push_back(idle(1, 0, 0, 0, 0, 2));
        tv.push_back(idle(1, 0, 0, 0, 1, 2));
        tv.push_back(idle(1, 1, 0, 0, 0, 0));
        // Two full-length codes under backpressure, drain, then clamp len 63 -> 34
        tv.push_back(mk(1, 1, 2'b11, 34'h3FFFFFFFF, 34, 34'hF, 34, 0, 0, 0, 1, 32'hFFFFFFFF, 0, 0));
        tv.push_back(idle(0, 0, 1, 32'hFFFFFFFF, 0, 0));
        tv.push_back(idle(1, 1, 1, 32'hC0000000, 0, 1));
        tv.push_back(idle(1, 1, 0, 0, 0, 2));
        tv.push_back(mk(1, 1, 2'b01, 34'h300000003, 63, 34'h3FFFFFFFF, 20, 0, 0, 1, 1, 32'hFC000000, 0, 2));
        tv.push_back(mk(1, 1, 2'b11, 34'h3FF, 0, 34'h3FF, 0, 1, 1, 0, 1, 32'h0C000000, 0, 3));
        tv.push_back(idle(1, 0, 0, 0, 0, 4));
        tv.push_back(idle(1, 0, 0, 0, 1, 4));
        tv.push_back(idle(1, 1, 0, 0, 0, 0));
        // Flush of a 5-bit block with a held word
        tv.push_back(mk(1, 1, 2'b01, 34'h16, 5, 0, 0, 1, 0, 0, 1, 32'hB0000000, 0, 0));
        tv.push_back(idle(0, 0, 1, 32'hB0000000, 0, 0));
        tv.push_back(idle(1, 0, 0, 0, 0, 1));
        tv.push_back(idle(1, 0, 0, 0, 1, 1));
        tv.push_back(idle(1, 1, 0, 0, 0, 0));
        // Empty last beat: no word, done with count 0
        tv.push_back(mk(1, 1, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        tv.push_back(idle(1, 0, 0, 0, 1, 0));
        tv.push_back(idle(1, 1, 0, 0, 0, 0));
        // Lane 1 only, then lane 0 with masked high bits
        tv.push_back(mk(1, 1, 2'b10, 34'h7, 3, 34'h5, 3, 0, 1, 1, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 2'b01, 34'h3FFFFFFFF, 29, 34'h3FFFFFFFF, 9, 0, 1, 1, 1, 32'hBFFFFFFF, 0, 0));
        tv.push_back(idle(1, 1, 0, 0, 0, 1));
        tv.push_back(mk(1, 1, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
        tv.push_back(idle(1, 0, 0, 0, 1, 1));
        tv.push_back(idle(1, 1, 0, 0, 0, 0));
        // Reset while 40 bits wait in flush, then a fresh block
        tv.push_back(mk(1, 1, 2'b11, 34'hFFFFF, 20, 0, 20, 1, 0, 0, 1, 32'hFFFFF000, 0, 0));
        tv.push_back(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            tv.push_back(idle(1, 1, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 2'b01, 34'h16, 5, 0, 0, 1, 1, 0, 1, 32'hB0000000, 0, 0));
        tv.push_back(idle(1, 0, 0, 0, 0, 1));
        tv.push_back(idle(1, 0, 0, 0, 1, 1));
        tv.push_back(idle(1, 1, 0, 0, 0, 0));

        for (int i = 0; i < tv.size(); i++) begin
            rst_n = tv[i].rst_n; vld = tv[i].vld; wr = tv[i].wr;
            c0 = tv[i].c0; l0 = tv[i].l0; c1 = tv[i].c1; l1 = tv[i].l1;
            last = tv[i].last; rdy = tv[i].rdy;
            @(posedge clk); #1;
            chk($sformatf("row%0d ready", i), o_ready, tv[i].e_rdy);
            chk($sformatf("row%0d valid", i), o_valid, tv[i].e_vld);
            chk($sformatf("row%0d data", i), o_data, tv[i].e_data);
            chk($sformatf("row%0d done", i), o_done, tv[i].e_done);
            chk($sformatf("row%0d count", i), o_word_count, tv[i].e_cnt);
        end

        // Random traffic against the bit-queue model; DUT is idle in RUN with empty acc here.
        mst = 0;
        mcnt = 0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            logic [63:0] r0, r1;
            logic [31:0] ew;
            bit er, ev;
            int sz, le;
            r0 = {$urandom(), $urandom()};
            r1 = {$urandom(), $urandom()};
            vld  = ($urandom_range(0, 9) < 7);
            wr   = 2'($urandom_range(0, 3));
            c0   = r0[33:0];
            c1   = r1[33:0];
            l0   = 6'($urandom_range(0, 40));
            l1   = 6'($urandom_range(0, 40));
            last = ($urandom_range(0, 149) == 0);
            rdy  = ($urandom_range(0, 9) < 6);

            sz = q.size();
            er = (mst == 0) && (sz <= 60);
            ev = (sz >= 32) || ((mst == 1) && (sz > 0));
            ew = '0;
            if (ev)
                for (int k = 0; k < 32 && k < sz; k++) ew[31-k] = q[k];
            chk($sformatf("rnd%0d ready", cyc), o_ready, er);
            chk($sformatf("rnd%0d valid", cyc), o_valid, ev);
            chk($sformatf("rnd%0d data", cyc), o_data, ew);
            chk($sformatf("rnd%0d done", cyc), o_done, (mst == 2));
            chk($sformatf("rnd%0d count", cyc), o_word_count, mcnt[15:0]);

            if (ev && rdy) begin
                for (int k = 0; k < 32 && q.size() > 0; k++) void'(q.pop_front());
                mcnt++;
            end
            if (vld && er) begin
                if (wr[0]) begin
                    le = (l0 > 34) ? 34 : int'(l0);
                    for (int j = le - 1; j >= 0; j--) q.push_back(c0[j]);
                end
                if (wr[1]) begin
                    le = (l1 > 34) ? 34 : int'(l1);
                    for (int j = le - 1; j >= 0; j--) q.push_back(c1[j]);
                end
            end
            if (mst == 2) begin
                mst = 0;
                mcnt = 0;
            end else if (mst == 0 && vld && er && last) begin
                mst = 1;
            end else if (mst == 1 && sz == 0) begin
                mst = 2;
            end
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
